// File: rtl/point_double_seq.sv
// -----------------------------------------------------------------------------
// point_double_seq
//
// Sequential affine point doubler for short-Weierstrass curves
// y^2 = x^3 + A*x + B over GF(P). A single bit-serial, MSB-first interleaved
// modular multiplier is shared by every product in the sequence. The modular
// inverse of 2Y is computed as (2Y)^(P-2) on that same multiplier.
//
//   R = 2*(X, Y):  s  = (3X^2 + A) / (2Y)
//                  Rx = s^2 - 2X
//                  Ry = s*(X - Rx) - Y
//
// Parameters
//   W  operand width in bits (P < 2^W)
//   P  odd field prime, P > 3
//   A  curve coefficient a, A < P
//
// Ports
//   Clk     clock, rising-edge
//   Reset   synchronous, active-high; aborts any operation in flight
//   Start   request; accepted when Busy=0, or in the Done cycle
//   Px, Py  affine input point (each < P), sampled at accept
//   InfIn   input is the point at infinity, sampled at accept
//   Busy    high from the cycle after accept through the Done cycle
//   Done    one-cycle pulse; Rx/Ry/InfOut valid
//   Rx, Ry  result coordinates; held until the next accept, then cleared
//   InfOut  result is the point at infinity
// -----------------------------------------------------------------------------
module point_double_seq #(
    parameter int           W = 256,
    parameter logic [W-1:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
    parameter logic [W-1:0] A = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] Px,
    input  logic [W-1:0] Py,
    input  logic         InfIn,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Rx,
    output logic [W-1:0] Ry,
    output logic         InfOut
);

    localparam int           CW = $clog2(W + 1);
    localparam int           IW = (W > 1) ? $clog2(W) : 1;
    // Fermat exponent for the inverse.
    localparam logic [W-1:0] E  = P - W'(2);

    typedef enum logic [2:0] {
        S_IDLE,   // waiting for Start
        S_LOAD,   // classify input; issue t0 = X*X
        S_MUL,    // multiplier iterating
        S_NEXT,   // capture a product and issue the next one
        S_ADD1,   // t1 = 3*t0 + A, t2 = 2*Y; issue first inverse square
        S_ADD2,   // Rx' = s2 - 2X, d = X - Rx'
        S_ADD3,   // Ry' = t - Y; register results
        S_FIN     // Done pulse
    } state_t;

    // Which product is currently in the multiplier.
    typedef enum logic [2:0] {
        OP_T0,     // X*X
        OP_SQ,     // r*r   (inverse, square step)
        OP_MULT2,  // r*t2  (inverse, multiply step)
        OP_S,      // t1*r
        OP_S2,     // s*s
        OP_D,      // d is ready; s*d still to be issued
        OP_T       // s*d
    } op_t;

    state_t        state, state_next;
    op_t           op, op_next;
    logic [IW-1:0] idx;

    logic [W-1:0]  x_reg, y_reg;
    logic          inf_reg;
    logic [W-1:0]  t1_reg, t2_reg, s_reg, d_reg, rx_reg;

    // Multiplier state
    logic [W-1:0]  mul_a, mul_b, acc;
    logic [CW-1:0] cnt;

    // Control decoded from the FSM
    logic          accept, mul_load, idx_dec, is_inf;
    logic [W-1:0]  mul_opa, mul_opb;

    // Datapath combinational results
    logic [W-1:0]  acc_step, two_x, rx_new, d_new;

    // Single conditional subtract; operands are < P so the W+1 bit sum is < 2P.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= {1'b0, P})
            sum = sum - {1'b0, P};
        return sum[W-1:0];
    endfunction

    // Single conditional add of P when the difference would go negative.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] diff;
        if (x >= y)
            diff = {1'b0, x} - {1'b0, y};
        else
            diff = {1'b0, x} + {1'b0, P} - {1'b0, y};
        return diff[W-1:0];
    endfunction

    assign is_inf = inf_reg || (y_reg == '0);

    // One MSB-first iteration: acc = 2*acc mod P, then + a if the current b bit is set.
    always_comb begin
        logic [W-1:0] dbl;
        dbl      = mod_add(acc, acc);
        acc_step = mul_b[W-1] ? mod_add(dbl, mul_a) : dbl;
        two_x    = mod_add(x_reg, x_reg);
        rx_new   = mod_sub(acc, two_x);
        d_new    = mod_sub(x_reg, rx_new);
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control decode
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        op_next    = op;
        accept     = 1'b0;
        mul_load   = 1'b0;
        mul_opa    = '0;
        mul_opb    = '0;
        idx_dec    = 1'b0;
        Busy       = (state != S_IDLE);
        Done       = (state == S_FIN);

        case (state)
            S_IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                if (is_inf) begin
                    state_next = S_FIN;
                end else begin
                    mul_load   = 1'b1;
                    mul_opa    = x_reg;
                    mul_opb    = x_reg;
                    op_next    = OP_T0;
                    state_next = S_MUL;
                end
            end

            S_MUL: begin
                if (cnt == CW'(1)) begin
                    case (op)
                        OP_T0:   state_next = S_ADD1;
                        OP_S2:   state_next = S_ADD2;
                        OP_T:    state_next = S_ADD3;
                        default: state_next = S_NEXT;
                    endcase
                end
            end

            S_ADD1: begin
                // Inverse starts from r = 1, so the first square is 1*1.
                mul_load   = 1'b1;
                mul_opa    = W'(1);
                mul_opb    = W'(1);
                op_next    = OP_SQ;
                state_next = S_MUL;
            end

            S_NEXT: begin
                state_next = S_MUL;
                mul_load   = 1'b1;
                case (op)
                    OP_SQ: begin
                        if (E[idx]) begin
                            mul_opa = acc;
                            mul_opb = t2_reg;
                            op_next = OP_MULT2;
                        end else if (idx == '0) begin
                            mul_opa = t1_reg;
                            mul_opb = acc;
                            op_next = OP_S;
                        end else begin
                            idx_dec = 1'b1;
                            mul_opa = acc;
                            mul_opb = acc;
                            op_next = OP_SQ;
                        end
                    end
                    OP_MULT2: begin
                        if (idx == '0) begin
                            mul_opa = t1_reg;
                            mul_opb = acc;
                            op_next = OP_S;
                        end else begin
                            idx_dec = 1'b1;
                            mul_opa = acc;
                            mul_opb = acc;
                            op_next = OP_SQ;
                        end
                    end
                    OP_S: begin
                        mul_opa = acc;
                        mul_opb = acc;
                        op_next = OP_S2;
                    end
                    OP_D: begin
                        mul_opa = s_reg;
                        mul_opb = d_reg;
                        op_next = OP_T;
                    end
                    default: begin
                        // Unreachable; fall back to idle rather than stall.
                        mul_load   = 1'b0;
                        state_next = S_IDLE;
                    end
                endcase
            end

            S_ADD2: begin
                op_next    = OP_D;
                state_next = S_NEXT;
            end

            S_ADD3: begin
                state_next = S_FIN;
            end

            S_FIN: begin
                // Busy falls after this cycle, so a Start seen here is taken.
                if (Start) begin
                    accept     = 1'b1;
                    state_next = S_LOAD;
                end else begin
                    state_next = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the datapath is reset along with the FSM so an aborted operation
    // leaves no stale operands or results visible on Rx/Ry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op      <= OP_T0;
            idx     <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            inf_reg <= 1'b0;
            t1_reg  <= '0;
            t2_reg  <= '0;
            s_reg   <= '0;
            d_reg   <= '0;
            rx_reg  <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            acc     <= '0;
            cnt     <= '0;
            Rx      <= '0;
            Ry      <= '0;
            InfOut  <= 1'b0;
        end else begin
            op <= op_next;

            if (accept) begin
                x_reg   <= Px;
                y_reg   <= Py;
                inf_reg <= InfIn;
                Rx      <= '0;
                Ry      <= '0;
                InfOut  <= 1'b0;
            end

            // Load cycle clears the accumulator; W iterations follow.
            if (mul_load) begin
                mul_a <= mul_opa;
                mul_b <= mul_opb;
                acc   <= '0;
                cnt   <= CW'(W);
            end else if (state == S_MUL) begin
                acc   <= acc_step;
                mul_b <= {mul_b[W-2:0], 1'b0};
                cnt   <= cnt - CW'(1);
            end

            case (state)
                S_LOAD: begin
                    if (is_inf) begin
                        Rx     <= '0;
                        Ry     <= '0;
                        InfOut <= 1'b1;
                    end
                end
                S_ADD1: begin
                    t1_reg <= mod_add(mod_add(mod_add(acc, acc), acc), A);
                    t2_reg <= mod_add(y_reg, y_reg);
                    idx    <= IW'(W - 1);
                end
                S_NEXT: begin
                    if (op == OP_S)
                        s_reg <= acc;
                    if (idx_dec)
                        idx <= idx - IW'(1);
                end
                S_ADD2: begin
                    rx_reg <= rx_new;
                    d_reg  <= d_new;
                end
                S_ADD3: begin
                    Rx     <= rx_reg;
                    Ry     <= mod_sub(acc, y_reg);
                    InfOut <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_double_seq.sv
// -----------------------------------------------------------------------------
// tb_point_double_seq
//
// Drives two instances of point_double_seq (W=5/P=23/A=1 and W=16/P=65521/A=7)
// and compares results, latency and handshake behaviour against a reference
// doubling model using plain integer arithmetic and an extended-Euclid inverse.
// -----------------------------------------------------------------------------
module tb_point_double_seq;

    logic        clk;
    logic        rst;

    logic        start5, inf5, busy5, done5, infout5;
    logic [4:0]  px5, py5, rx5, ry5;

    logic        start16, inf16, busy16, done16, infout16;
    logic [15:0] px16, py16, rx16, ry16;

    int n_checks = 0;
    int n_errors = 0;

    point_double_seq #(.W(5), .P(5'd23), .A(5'd1)) dut5 (
        .Clk(clk), .Reset(rst), .Start(start5), .Px(px5), .Py(py5), .InfIn(inf5),
        .Busy(busy5), .Done(done5), .Rx(rx5), .Ry(ry5), .InfOut(infout5)
    );

    point_double_seq #(.W(16), .P(16'd65521), .A(16'd7)) dut16 (
        .Clk(clk), .Reset(rst), .Start(start16), .Px(px16), .Py(py16), .InfIn(inf16),
        .Busy(busy16), .Done(done16), .Rx(rx16), .Ry(ry16), .InfOut(infout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint md(input longint v, input longint p);
        return ((v % p) + p) % p;
    endfunction

    function automatic longint inv_mod(input longint v, input longint p);
        longint t, nt, r, nr, q, tmp;
        t = 0; nt = 1; r = p; nr = md(v, p);
        while (nr != 0) begin
            q   = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        return md(t, p);
    endfunction

    task automatic ref_double(input longint p, input longint a, input longint x, input longint y,
                              input bit inf, output longint rx, output longint ry, output bit rinf);
        longint s;
        if (inf || y == 0) begin
            rx = 0; ry = 0; rinf = 1'b1;
        end else begin
            s    = md(md(3 * x * x + a, p) * inv_mod(2 * y, p), p);
            rx   = md(s * s - 2 * x, p);
            ry   = md(s * md(x - rx, p) - y, p);
            rinf = 1'b0;
        end
    endtask

    function automatic int finite_latency(input int w, input longint p);
        return (w + 1) * (w + $countones(p - 2) + 4) + 3;
    endfunction

    // ---------------- DUT access by instance select ----------------
    function automatic logic [15:0] get_rx(input int sel);
        return (sel != 0) ? rx16 : {11'b0, rx5};
    endfunction
    function automatic logic [15:0] get_ry(input int sel);
        return (sel != 0) ? ry16 : {11'b0, ry5};
    endfunction
    function automatic logic get_inf(input int sel);
        return (sel != 0) ? infout16 : infout5;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy16 : busy5;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel != 0) ? done16 : done5;
    endfunction

    task automatic drive(input int sel, input logic s, input longint x, input longint y, input logic inf);
        if (sel == 0) begin
            start5 = s; px5 = x[4:0]; py5 = y[4:0]; inf5 = inf;
        end else begin
            start16 = s; px16 = x[15:0]; py16 = y[15:0]; inf16 = inf;
        end
    endtask

    task automatic set_start(input int sel, input logic s);
        if (sel == 0) start5 = s;
        else          start16 = s;
    endtask

    // Called at a negedge. Issues a request, follows it to Done, and returns at
    // the negedge inside the Done cycle so the caller may chain another Start.
    task automatic run_op(input int sel, input longint x, input longint y, input bit inf,
                          input bit repulse, input string tag,
                          output longint erx, output longint ery, output bit einf);
        longint p, a;
        int     w, lat, k, busy_low;
        p = (sel != 0) ? 65521 : 23;
        a = (sel != 0) ? 7 : 1;
        w = (sel != 0) ? 16 : 5;
        ref_double(p, a, x, y, inf, erx, ery, einf);
        lat = (inf || y == 0) ? 2 : finite_latency(w, p);

        drive(sel, 1'b1, x, y, inf);
        @(posedge clk);                 // accepting edge
        @(negedge clk);                 // cycle 1
        set_start(sel, 1'b0);
        k = 1;
        busy_low = 0;
        check({tag, "_clr"}, {get_rx(sel), get_ry(sel), 7'b0, get_inf(sel)}, 64'd0);
        while (!get_done(sel) && k < lat + 20) begin
            if (!get_busy(sel)) busy_low++;
            if (repulse) set_start(sel, (k == 10 || k == 40));
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_busy"}, 64'(busy_low + (get_busy(sel) ? 0 : 1)), 64'd0);
        check({tag, "_rx"}, 64'(get_rx(sel)), 64'(erx));
        check({tag, "_ry"}, 64'(get_ry(sel)), 64'(ery));
        check({tag, "_inf"}, 64'(get_inf(sel)), 64'(einf));
    endtask

    // One cycle after Done with no new Start: idle, results held.
    task automatic idle_check(input int sel, input string tag,
                              input longint erx, input longint ery, input bit einf);
        @(negedge clk);
        check({tag, "_idle"}, {61'b0, get_busy(sel), get_done(sel), 1'b0}, 64'd0);
        check({tag, "_hold"}, {31'b0, get_inf(sel), get_rx(sel), get_ry(sel)},
              {31'b0, einf, 16'(erx), 16'(ery)});
    endtask

    initial begin
        longint erx, ery;
        bit     einf;
        int     dones;
        longint x, y;
        bit     inf;

        rst = 1'b1;
        drive(0, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset5", {busy5, done5, infout5, 11'b0, rx5, ry5}, 64'd0);
        check("reset16", {busy16, done16, infout16, rx16, ry16}, 64'd0);
        rst = 1'b0;

        // Scenario 1 with known answer
        run_op(0, 3, 10, 1'b0, 1'b0, "s1", erx, ery, einf);
        check("s1_kat", {rx5, ry5}, {5'd7, 5'd12});
        idle_check(0, "s1", erx, ery, einf);

        // Y = 0 and point at infinity
        run_op(0, 3, 0, 1'b0, 1'b0, "y0", erx, ery, einf);
        idle_check(0, "y0", erx, ery, einf);
        run_op(0, 3, 10, 1'b1, 1'b0, "inf", erx, ery, einf);
        idle_check(0, "inf", erx, ery, einf);

        // Reset while idle clears held results
        run_op(0, 3, 10, 1'b0, 1'b0, "s1b", erx, ery, einf);
        idle_check(0, "s1b", erx, ery, einf);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_idle", {busy5, done5, infout5, rx5, ry5}, 64'd0);

        // Reset mid-operation at cycle 30
        drive(0, 1'b1, 3, 10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort", {busy5, done5, infout5, rx5, ry5}, 64'd0);
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done5) dones++;
        end
        check("rst_nodone", 64'(dones), 64'd0);
        run_op(0, 3, 10, 1'b0, 1'b0, "s1c", erx, ery, einf);
        idle_check(0, "s1c", erx, ery, einf);

        // Start re-pulsed while busy, then Start in the Done cycle
        run_op(0, 3, 10, 1'b0, 1'b1, "repulse", erx, ery, einf);
        run_op(0, 5, 8, 1'b0, 1'b0, "chain", erx, ery, einf);
        idle_check(0, "chain", erx, ery, einf);

        // Randomised runs on the small field, some chained in the Done cycle
        for (int i = 0; i < 20; i++) begin
            x   = $urandom_range(0, 22);
            y   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 22);
            inf = ($urandom_range(0, 7) == 0);
            run_op(0, x, y, inf, 1'b0, "rnd5", erx, ery, einf);
            if ($urandom_range(0, 1) == 0)
                idle_check(0, "rnd5", erx, ery, einf);
        end
        idle_check(0, "rnd5_end", erx, ery, einf);

        // Randomised runs on the 16-bit field
        for (int i = 0; i < 8; i++) begin
            x   = $urandom_range(0, 65520);
            y   = (i == 3) ? 0 : $urandom_range(1, 65520);
            run_op(1, x, y, 1'b0, 1'b0, "rnd16", erx, ery, einf);
            if ((i % 2) == 0)
                idle_check(1, "rnd16", erx, ery, einf);
        end
        idle_check(1, "rnd16_end", erx, ery, einf);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/point_double_seq.md
Name: point_double_seq

Overview:
- Sequential, parametrised-width affine point doubler for short-Weierstrass curves y^2 = x^3 + A*x + B over GF(P).
- One internal bit-serial modular multiplier is time-shared by a microsequencing FSM; inversion uses Fermat exponentiation (x^(P-2)) on that same multiplier.
- Adds a Start/Busy/Done handshake, a programmable coefficient A, and point-at-infinity handling.
- Serves as the doubling primitive for the scalar-multiply controller.

Parameters:
W, 256, operand/result width in bits; P < 2^W required.
P, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field prime; must be odd and > 3.
A, 0, curve coefficient a; must be < P.

Ports:
Clk  input  1  clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high.
Start  input  1  request; accepted on an edge where Start=1 and Busy=0.
Px  input  W  affine x; must be < P; sampled at accept.
Py  input  W  affine y; must be < P; sampled at accept.
InfIn  input  1  input is the point at infinity; sampled at accept.
Busy  output  1  high from the cycle after accept until the Done cycle, inclusive.
Done  output  1  one-cycle pulse; results valid.
Rx  output  W  result x.
Ry  output  W  result y.
InfOut  output  1  result is the point at infinity.

Behaviour:
- Reset: FSM to IDLE; Busy=0, Done=0, Rx=0, Ry=0, InfOut=0.
- Reset mid-operation aborts immediately with the same values; no partial result is emitted.
- Handshake:
  - Start while Busy=1 is ignored.
  - Rx/Ry/InfOut hold their value from Done until the next accepted Start, then clear to 0 in the following cycle.
  - Start may be asserted in the Done cycle; it is accepted because Busy drops after that cycle.
- Multiplier (MUL), interleaved MSB-first:
  - 1 load cycle, then W iterations of acc = 2*acc mod P; if b[i]=1, acc = acc + a mod P.
  - Exactly W+1 cycles per product.
  - Every mod add/sub is a single conditional subtract/add of P; intermediates are W+1 bits.
- FSM states and sequence:
  - IDLE -> LOAD: latch X, Y, Inf.
  - LOAD: if Inf=1 or Y==0 -> FIN with InfOut=1, Rx=Ry=0. Else -> MUL t0=X*X.
  - ADD1 (1 cycle): t1=3*t0+A mod P; t2=2*Y mod P.
  - INV: r=1; for i=W-1 down to 0: r=r*r; if E[i], r=r*t2, where E=P-2. All W bit positions are processed, with no leading-zero skip.
  - MUL s=t1*r; MUL s2=s*s.
  - ADD2 (1 cycle): Rx'=s2-2X mod P; d=X-Rx' mod P.
  - MUL t=s*d.
  - ADD3 (1 cycle): Ry'=t-Y mod P.
  - FIN: register outputs, Done=1, -> IDLE.
- Latency:
  - Let M = W + popcount(P-2) + 4 products.
  - Finite path: Done is high exactly L = (W+1)*M + 3 cycles after the accepting edge.
  - Infinity/Y=0 path: Done is high 2 cycles after the accepting edge.
- Inputs >= P produce undefined values but must not hang the FSM; latency is unchanged.

Test Plan:
1. W=5, P=23, A=1; Start with (Px,Py)=(3,10) -> Done at cycle 75 (M=12); Rx=7, Ry=12, InfOut=0; Busy high cycles 1..75.
2. W=5, P=23, A=1; (Px,Py)=(3,0) -> Done at cycle 2; Rx=0, Ry=0, InfOut=1.
3. W=5, P=23, A=1; InfIn=1, Px=3, Py=10 -> Done at cycle 2; InfOut=1.
4. Default params (secp256k1); Start with Gx=79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, Gy=483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8 -> Rx=C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, Ry=1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A, latency per formula.
5. W=5, P=23, A=1; pulse Reset at cycle 30 of scenario 1 -> Busy=0, Done never pulses, outputs 0. A new Start then completes scenario 1 correctly.
6. W=5, P=23, A=1:
   - Start re-pulsed at cycles 10 and 40 of scenario 1 -> ignored; single Done at cycle 75.
   - Start asserted in the Done cycle -> accepted; Rx/Ry clear next cycle.
